pipeline_ctrl: RTL and testbench

//  Central sequencer for the 4-stage F/D/E/W core pipeline. Owns per-stage valid bits and the PC source select.

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Sequencer for the 4-stage F/D/E/W pipeline: owns stage valid bits, pipeline-register
// load enables and PC source select, runs the IDLE/RUN/DRAIN/DONE lifecycle and perf counters.
module pipeline_ctrl #(
  parameter int CNT_W      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect,
  input  logic                  mem_busy,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_use_rs1,
  input  logic                  de_use_rs2,
  output logic [3:0]            valid,
  output logic                  fd_load,
  output logic                  de_load,
  output logic                  ew_load,
  output logic [1:0]            pc_sel,
  output logic [1:0]            state,
  output logic                  done,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_NEXT  = 2'b01;
  localparam logic [1:0] PC_REDIR = 2'b10;
  localparam logic [1:0] PC_BOOT  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [3:0]       r_valid;
  logic             r_done;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_active;
  logic       w_hazard;
  logic       w_halt_eff;
  logic       w_fetch_on;
  logic [3:0] w_valid_nxt;
  logic       w_stall_inc;
  logic       w_flush_inc;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_halt_eff = halt_req & r_valid[3];
  assign w_fetch_on = (r_state == S_RUN) & ~w_halt_eff;
  assign w_hazard   = r_valid[1] & r_valid[2] & ex_is_load & (ex_rd != '0) &
                      ((de_use_rs1 & (de_rs1 == ex_rd)) | (de_use_rs2 & (de_rs2 == ex_rd)));

  // Per-cycle pipeline action, highest priority first: freeze, redirect, load-use bubble, advance.
  always_comb begin
    w_valid_nxt = r_valid;
    fd_load     = 1'b0;
    de_load     = 1'b0;
    ew_load     = 1'b0;
    pc_sel      = PC_HOLD;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (w_active) begin
      if (mem_busy) begin
        w_stall_inc = 1'b1;
      end else if (redirect && r_valid[2]) begin
        w_valid_nxt = {r_valid[2], 1'b0, 1'b0, w_fetch_on};
        ew_load     = 1'b1;
        pc_sel      = PC_REDIR;
        w_flush_inc = 1'b1;
      end else if (w_hazard) begin
        w_valid_nxt = {r_valid[2], 1'b0, r_valid[1], r_valid[0]};
        ew_load     = 1'b1;
        w_stall_inc = 1'b1;
      end else begin
        w_valid_nxt = {r_valid[2:0], w_fetch_on};
        fd_load     = 1'b1;
        de_load     = 1'b1;
        ew_load     = 1'b1;
        pc_sel      = w_fetch_on ? PC_NEXT : PC_HOLD;
      end
    end else if (start) begin
      w_valid_nxt = 4'b0001;
      pc_sel      = PC_BOOT;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_valid     <= 4'b0000;
      r_done      <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_done      <= 1'b0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt, 1'b1);
          r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_inc);
          r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_inc);
          // A frozen pipeline does not retire, so halt only takes effect once W advances.
          if (r_state == S_RUN) begin
            if (w_halt_eff && !mem_busy) r_state <= S_DRAIN;
          end else if (w_valid_nxt == 4'b0000) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid     = r_valid;
  assign state     = r_state;
  assign done      = r_done;
  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vectors, a per-cycle reference model compared on every
// falling edge, and literal expectations at the interesting points of each scenario.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int RW    = 5;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start, halt_req, redirect, mem_busy, ex_is_load;
  logic [RW-1:0]   ex_rd, de_rs1, de_rs2;
  logic            de_use_rs1, de_use_rs2;
  logic [3:0]      valid;
  logic            fd_load, de_load, ew_load;
  logic [1:0]      pc_sel, state;
  logic            done;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req), .redirect(redirect),
    .mem_busy(mem_busy), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .de_rs1(de_rs1),
    .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .valid(valid),
    .fd_load(fd_load), .de_load(de_load), .ew_load(ew_load), .pc_sel(pc_sel),
    .state(state), .done(done), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, need completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lifecycle: 0 idle, 1 run, 2 drain, 3 done. mv[i] = stage i holds a live instruction.
  localparam int K_NONE = 0, K_BOOT = 1, K_BUSY = 2, K_REDIR = 3, K_HAZ = 4, K_NORM = 5;
  int     m_st = 0;
  bit [3:0] mv = 4'b0;
  longint m_cyc = 0, m_stl = 0, m_fl = 0;

  function automatic longint sat(input longint x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  function automatic bit m_fetch();
    return (m_st == 1) && !(halt_req && mv[3]);
  endfunction

  function automatic int m_kind();
    bit src1, src2;
    if (!(m_st == 1 || m_st == 2)) return start ? K_BOOT : K_NONE;
    if (mem_busy) return K_BUSY;
    if (redirect && mv[2]) return K_REDIR;
    src1 = de_use_rs1 && (de_rs1 == ex_rd);
    src2 = de_use_rs2 && (de_rs2 == ex_rd);
    if (mv[1] && mv[2] && ex_is_load && ex_rd != 0 && (src1 || src2)) return K_HAZ;
    return K_NORM;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int k, st0;
    bit f, h;
    bit [3:0] nv;
    if (!rstn) begin
      m_st = 0; mv = 4'b0; m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      k = m_kind(); f = m_fetch(); h = halt_req && mv[3]; st0 = m_st;
      nv = mv;
      case (k)
        K_BOOT:  begin m_st = 1; nv = 4'b0001; m_cyc = 0; m_stl = 0; m_fl = 0; end
        K_BUSY:  m_stl = sat(m_stl);
        K_REDIR: begin nv = 4'b0; nv[3] = mv[2]; nv[0] = f; m_fl = sat(m_fl); end
        K_HAZ:   begin nv[3] = mv[2]; nv[2] = 1'b0; m_stl = sat(m_stl); end
        K_NORM:  nv = {mv[2:0], f};
        default: ;
      endcase
      if (k >= K_BUSY) m_cyc = sat(m_cyc);
      if (st0 == 1 && h && k != K_BUSY) m_st = 2;
      else if (st0 == 2 && nv == 4'b0) m_st = 3;
      mv = nv;
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    int k;
    k = m_kind();
    exp_q = {};
    exp_q.push_back(32'(mv));
    exp_q.push_back(32'(m_st));
    exp_q.push_back(32'(m_st == 3));
    exp_q.push_back(32'(m_cyc));
    exp_q.push_back(32'(m_stl));
    exp_q.push_back(32'(m_fl));
    case (k)
      K_BOOT:  exp_q.push_back(32'd3);
      K_REDIR: exp_q.push_back(32'd2);
      K_NORM:  exp_q.push_back(m_fetch() ? 32'd1 : 32'd0);
      default: exp_q.push_back(32'd0);
    endcase
    exp_q.push_back(32'(k == K_NORM));
    exp_q.push_back(32'(k == K_NORM));
    exp_q.push_back(32'(k == K_NORM || k == K_REDIR || k == K_HAZ));
    chk("m_valid",  32'(valid),     exp_q.pop_front());
    chk("m_state",  32'(state),     exp_q.pop_front());
    chk("m_done",   32'(done),      exp_q.pop_front());
    chk("m_cycle",  32'(cycle_cnt), exp_q.pop_front());
    chk("m_stall",  32'(stall_cnt), exp_q.pop_front());
    chk("m_flush",  32'(flush_cnt), exp_q.pop_front());
    chk("m_pc_sel", 32'(pc_sel),    exp_q.pop_front());
    chk("m_fd",     32'(fd_load),   exp_q.pop_front());
    chk("m_de",     32'(de_load),   exp_q.pop_front());
    chk("m_ew",     32'(ew_load),   exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    start = 0; halt_req = 0; redirect = 0; mem_busy = 0; ex_is_load = 0;
    ex_rd = '0; de_rs1 = '0; de_rs2 = '0; de_use_rs1 = 0; de_use_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard_rs1(input logic [RW-1:0] r);
    ex_is_load = 1; ex_rd = r; de_rs1 = r; de_use_rs1 = 1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", 32'(pc_sel), 32'd0);
    rstn = 1;
    tick();

    // fill after start
    start = 1; #1;
    chk("boot_pc", 32'(pc_sel), 32'd3);
    tick(); start = 0;
    chk("fill1", 32'(valid), 32'b0001);
    chk("run_state", 32'(state), 32'd1);
    #1; chk("next_pc", 32'(pc_sel), 32'd1);
    tick(); chk("fill2", 32'(valid), 32'b0011);
    tick(); chk("fill3", 32'(valid), 32'b0111);
    tick(); chk("fill4", 32'(valid), 32'b1111);

    // load-use on rs1
    set_hazard_rs1(5); #1;
    chk("lu_fd", 32'(fd_load), 32'd0);
    chk("lu_de", 32'(de_load), 32'd0);
    chk("lu_ew", 32'(ew_load), 32'd1);
    tick(); clear_inputs();
    chk("lu_valid", 32'(valid), 32'b1011);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    tick(); tick();

    // x0 destination is never a hazard; rs2 match is
    ex_is_load = 1; ex_rd = 0; de_rs1 = 0; de_use_rs1 = 1; #1;
    chk("x0_nohaz", 32'(fd_load), 32'd1);
    ex_rd = 7; de_rs1 = 3; de_rs2 = 7; de_use_rs2 = 1; #1;
    chk("rs2_haz", 32'(fd_load), 32'd0);
    tick(); clear_inputs();
    chk("rs2_valid", 32'(valid), 32'b1011);
    chk("rs2_stall", 32'(stall_cnt), 32'd2);
    tick(); tick();

    // redirect
    redirect = 1; #1;
    chk("redir_pc", 32'(pc_sel), 32'd2);
    tick(); redirect = 0;
    chk("redir_valid", 32'(valid), 32'b1001);
    chk("redir_flush", 32'(flush_cnt), 32'd1);
    tick(); tick(); tick();
    chk("refill", 32'(valid), 32'b1111);

    // mem_busy dominates hazard and redirect
    mem_busy = 1; redirect = 1; set_hazard_rs1(5); #1;
    chk("busy_pc", 32'(pc_sel), 32'd0);
    repeat (3) tick();
    clear_inputs();
    chk("busy_valid", 32'(valid), 32'b1111);
    chk("busy_stall", 32'(stall_cnt), 32'd5);
    chk("busy_flush", 32'(flush_cnt), 32'd1);

    // redirect outranks a simultaneous hazard
    redirect = 1; set_hazard_rs1(9);
    tick(); clear_inputs();
    chk("rh_valid", 32'(valid), 32'b1001);
    chk("rh_flush", 32'(flush_cnt), 32'd2);
    tick(); tick(); tick();

    // start while running is ignored; cycle counter saturates
    start = 1; tick(); start = 0;
    chk("start_in_run", 32'(state), 32'd1);
    repeat (16) tick();
    chk("cyc_sat", 32'(cycle_cnt), 32'd15);

    // halt and drain, halt_req ignored while draining
    halt_req = 1; #1;
    chk("halt_pc", 32'(pc_sel), 32'd0);
    tick();
    chk("drain_state", 32'(state), 32'd2);
    chk("drain1", 32'(valid), 32'b1110);
    tick(); halt_req = 0;
    chk("drain2", 32'(valid), 32'b1100);
    tick(); chk("drain3", 32'(valid), 32'b1000);
    tick();
    chk("drain4", 32'(valid), 32'b0000);
    chk("done_state", 32'(state), 32'd3);
    chk("done_flag", 32'(done), 32'd1);
    mem_busy = 1; tick(); tick(); mem_busy = 0;
    chk("done_hold", 32'(state), 32'd3);

    // restart clears counters
    start = 1; #1;
    chk("reboot_pc", 32'(pc_sel), 32'd3);
    tick(); start = 0;
    chk("rb_state", 32'(state), 32'd1);
    chk("rb_valid", 32'(valid), 32'b0001);
    chk("rb_done", 32'(done), 32'd0);
    chk("rb_cycle", 32'(cycle_cnt), 32'd0);
    chk("rb_stall", 32'(stall_cnt), 32'd0);
    chk("rb_flush", 32'(flush_cnt), 32'd0);
    tick(); tick(); tick();

    // redirect inside drain flushes without refetch
    halt_req = 1; tick(); halt_req = 0;
    redirect = 1; #1;
    chk("dr_redir_pc", 32'(pc_sel), 32'd2);
    tick(); redirect = 0;
    chk("dr_redir_valid", 32'(valid), 32'b1000);
    chk("dr_redir_flush", 32'(flush_cnt), 32'd1);
    tick();
    chk("dr_done", 32'(done), 32'd1);

    // asynchronous reset mid-run
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    #2 rstn = 0; #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_cycle", 32'(cycle_cnt), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_pc", 32'(pc_sel), 32'd0);
    tick(); rstn = 1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
